// File: rtl/rom_stream_pkg.sv
// Shared types and default widths for the ROM stream reader.
package rom_stream_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rsr_state_t;

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO with occupancy count; head is visible on rd_data_o.
module rom_stream_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;
  logic          full;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign pop       = rd_en_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({wr_en_i, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The issuer's credit check must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en_i && full && !rd_en_i));

endmodule

// File: rtl/rom_stream_reader.sv
// Sweeps an address range through a synchronous ROM and streams the read data out
// as valid/ready with a last-word marker and a running checksum.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned ROM_LAT    = 1,  // 1..3
  parameter int unsigned FIFO_DEPTH = 4   // >= ROM_LAT+1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count_m1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  rsr_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] remain_q, remain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] csum_q, csum_d;
  // Stage 0 tracks the address register itself; stages 1..ROM_LAT follow the ROM
  // latency, so the top stage flags that rom_data holds a requested word now.
  logic [ROM_LAT:0] pvld_q, pvld_d, plast_q, plast_d;

  logic          issue, issue_last, credit_ok, pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [DW:0]   fifo_head;

  assign pop       = m_valid && m_ready;
  // Every in-flight read owns a FIFO slot, so a landing word always fits.
  assign credit_ok = (32'(fifo_count) + 32'($countones(pvld_q))) < 32'(FIFO_DEPTH);

  // FSM, address counter and checksum next-state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    csum_d     = csum_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    if (pop) csum_d = csum_q + m_data;
    unique case (state_q)
      IDLE: begin
        // done_q still high means the previous sweep just ended; ignore start then.
        if (start && !done_q) begin
          addr_d     = base_addr;
          issue      = 1'b1;
          issue_last = (count_m1 == '0);
          remain_d   = count_m1 - AW'(1);
          busy_d     = 1'b1;
          csum_d     = '0;
          state_d    = (count_m1 == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          addr_d     = addr_q + AW'(1);
          issue      = 1'b1;
          issue_last = (remain_q == '0);
          remain_d   = remain_q - AW'(1);
          if (remain_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pvld_d  = {pvld_q[ROM_LAT-1:0], issue};
    plast_d = {plast_q[ROM_LAT-1:0], issue_last};
  end

  // Control and pipeline state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      csum_q   <= '0;
      pvld_q   <= '0;
      plast_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      csum_q   <= csum_d;
      pvld_q   <= pvld_d;
      plast_q  <= plast_d;
    end
  end

  rom_stream_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (pvld_q[ROM_LAT]),
    .wr_data_i ({plast_q[ROM_LAT], rom_data}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign rom_addr = addr_q;
  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_head[DW-1:0];
  assign m_last   = fifo_head[DW];
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = csum_q;

endmodule
